// File: rtl/data_bus_tx_nlane.sv
// N-lane USB4 logical-layer TX data bus: transport byte FIFO, ordered-set generator and lane striping.
// Optional pad counter output o_underflow_cnt is enabled by defining USB4_UNDERFLOW_CNT_EN.
module data_bus_tx_nlane #(
    parameter int NUM_LANES  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int OS_LEN     = 4
) (
    input  logic                          i_fsm_clk,
    input  logic                          i_rst,
    input  logic [3:0]                    i_d_sel,
    input  logic                          i_bonded,
    input  logic [7:0]                    i_tl_data,
    input  logic                          i_tl_valid,
    output logic                          o_tl_ready,
    output logic [8*NUM_LANES-1:0]        o_lane_tx,
    output logic                          o_tx_lanes_on,
    output logic                          o_os_sent,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
`ifdef USB4_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]                    o_underflow_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_OS, S_DATA} state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_code, w_code_nxt;
    logic [3:0]             r_k, w_k_nxt;

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]          r_level;

    logic                   w_flush, w_push, w_pad, w_bond_eff, w_os_start, w_is_os_code;
    logic [LW-1:0]          w_pop_cnt;
    logic [8*NUM_LANES-1:0] w_lane_nxt;
    logic                   w_on_nxt, w_os_nxt;
    logic [8*NUM_LANES-1:0] r_lane_tx;
    logic                   r_on, r_os_sent;

    assign w_flush      = (i_d_sel == 4'd0);
    assign w_is_os_code = (i_d_sel >= 4'd1) && (i_d_sel <= 4'd4);
    assign w_bond_eff   = i_bonded || (NUM_LANES == 1);
    assign o_tl_ready   = (r_level < LW'(FIFO_DEPTH)) && !i_rst && !w_flush;
    assign w_push       = i_tl_valid && o_tl_ready;
    assign w_os_start   = (r_k == 4'(OS_LEN - 1));

    // FSM: state register
    always_ff @(posedge i_fsm_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_code  <= 4'd0;
            r_k     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // FSM: next state; an ordered set always runs to completion unless flushed
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_k_nxt     = r_k;
        if (w_flush) begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = 4'd0;
        end else begin
            case (r_state)
                S_OS: begin
                    w_k_nxt = r_k + 4'd1;
                    if (w_os_start) begin
                        w_k_nxt = 4'd0;
                        if (w_is_os_code) begin
                            w_code_nxt = i_d_sel;
                        end else if (i_d_sel == 4'd8) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    if (w_is_os_code) begin
                        w_state_nxt = S_OS;
                        w_code_nxt  = i_d_sel;
                        w_k_nxt     = 4'd0;
                    end else if (i_d_sel == 4'd8) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    // FSM: outputs and pop decision (registered one cycle later)
    always_comb begin
        w_lane_nxt = '0;
        w_on_nxt   = 1'b0;
        w_os_nxt   = 1'b0;
        w_pop_cnt  = '0;
        w_pad      = 1'b0;
        if (!w_flush) begin
            case (r_state)
                S_OS: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        w_lane_nxt[8*i +: 8] = {r_code, r_k};
                    end
                    w_on_nxt = 1'b1;
                    w_os_nxt = w_os_start;
                end
                S_DATA: begin
                    w_on_nxt = 1'b1;
                    if (w_bond_eff && (r_level >= LW'(NUM_LANES))) begin
                        w_pop_cnt = LW'(NUM_LANES);
                        for (int i = 0; i < NUM_LANES; i++) begin
                            w_lane_nxt[8*i +: 8] = r_mem[r_rd_ptr + AW'(i)];
                        end
                    end else if (!w_bond_eff && (r_level != '0)) begin
                        w_pop_cnt       = LW'(1);
                        w_lane_nxt[7:0] = r_mem[r_rd_ptr];
                    end else begin
                        w_pad = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_fsm_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lane_tx <= '0;
            r_on      <= 1'b0;
            r_os_sent <= 1'b0;
        end else begin
            r_lane_tx <= w_lane_nxt;
            r_on      <= w_on_nxt;
            r_os_sent <= w_os_nxt;
        end
    end

    always_ff @(posedge i_fsm_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tl_data;
        end
    end

    always_ff @(posedge i_fsm_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + AW'(w_pop_cnt);
            r_level  <= r_level + LW'(w_push) - w_pop_cnt;
        end
    end

`ifdef USB4_UNDERFLOW_CNT_EN
    logic [7:0] r_underflow_cnt;
    always_ff @(posedge i_fsm_clk or posedge i_rst) begin
        if (i_rst) begin
            r_underflow_cnt <= 8'd0;
        end else if (w_flush) begin
            r_underflow_cnt <= 8'd0;
        end else if (w_pad && (r_underflow_cnt != 8'hFF)) begin
            r_underflow_cnt <= r_underflow_cnt + 8'd1;
        end
    end
    assign o_underflow_cnt = r_underflow_cnt;
`endif

    assign o_lane_tx     = r_lane_tx;
    assign o_tx_lanes_on = r_on;
    assign o_os_sent     = r_os_sent;
    assign o_fifo_level  = r_level;

endmodule

// File: tb/tb_data_bus_tx_nlane.sv
// Directed testbench for data_bus_tx_nlane with default parameters (2 lanes, 8-deep FIFO, OS_LEN 4).
module tb_data_bus_tx_nlane;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  d_sel;
    logic        bonded;
    logic [7:0]  tl_data;
    logic        tl_valid;
    logic        tl_ready;
    logic [15:0] lane_tx;
    logic        tx_on;
    logic        os_sent;
    logic [3:0]  level;
`ifdef USB4_UNDERFLOW_CNT_EN
    logic [7:0]  ucnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    data_bus_tx_nlane #(.NUM_LANES(2), .FIFO_DEPTH(8), .OS_LEN(4)) dut (
        .i_fsm_clk     (clk),
        .i_rst         (rst),
        .i_d_sel       (d_sel),
        .i_bonded      (bonded),
        .i_tl_data     (tl_data),
        .i_tl_valid    (tl_valid),
        .o_tl_ready    (tl_ready),
        .o_lane_tx     (lane_tx),
        .o_tx_lanes_on (tx_on),
        .o_os_sent     (os_sent),
        .o_fifo_level  (level)
`ifdef USB4_UNDERFLOW_CNT_EN
        ,
        .o_underflow_cnt (ucnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        tl_valid = 1'b0;
        d_sel = 4'd0;
        tick();
        d_sel = 4'd15;
        tick();
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            tl_valid = 1'b1;
            tl_data  = first + 8'(i);
            tick();
        end
        tl_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; d_sel = 4'd15; bonded = 1'b1; tl_valid = 1'b0; tl_data = 8'h00;
        tick(); tick();
        n_tests++; if (lane_tx !== 16'h0000) begin n_fail++; $display("FAIL reset_lane got=%h exp=0000", lane_tx); end
        n_tests++; if (tx_on !== 1'b0 || os_sent !== 1'b0) begin n_fail++; $display("FAIL reset_flags on=%b os=%b exp=0/0", tx_on, os_sent); end
        n_tests++; if (level !== 4'd0 || tl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fifo level=%0d rdy=%b exp=0/0", level, tl_ready); end
        rst = 1'b0;
        #1;
        n_tests++; if (tl_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", tl_ready); end
    endtask

    task automatic test_os();
        logic [7:0] exp_b [8];
        logic       exp_os [8];
        exp_b = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30, 8'h31, 8'h32, 8'h33};
        exp_os = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        go_idle();
        d_sel = 4'd3;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 5) d_sel = 4'd8;
            n_tests++;
            if (lane_tx !== {exp_b[i], exp_b[i]} || os_sent !== exp_os[i] || tx_on !== 1'b1) begin
                n_fail++;
                $display("FAIL os_byte%0d lane=%h os=%b on=%b exp=%h%h/%b/1", i, lane_tx, os_sent, tx_on, exp_b[i], exp_b[i], exp_os[i]);
            end
        end
        tick();
        n_tests++; if (lane_tx !== 16'h0000 || tx_on !== 1'b1 || os_sent !== 1'b0) begin n_fail++; $display("FAIL os_to_data lane=%h on=%b os=%b exp=0000/1/0", lane_tx, tx_on, os_sent); end
    endtask

    task automatic test_bonded();
        logic [15:0] exp_l [5];
        logic [3:0]  exp_lv [5];
        exp_l  = '{16'hA1A0, 16'hA3A2, 16'hA5A4, 16'h0000, 16'h0000};
        exp_lv = '{4'd4, 4'd2, 4'd0, 4'd0, 4'd0};
        go_idle();
        push_bytes(8'hA0, 6);
        n_tests++; if (level !== 4'd6) begin n_fail++; $display("FAIL bonded_fill level=%0d exp=6", level); end
        d_sel = 4'd8; bonded = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (lane_tx !== exp_l[i] || level !== exp_lv[i] || tx_on !== 1'b1) begin
                n_fail++;
                $display("FAIL bonded_step%0d lane=%h level=%0d on=%b exp=%h/%0d/1", i, lane_tx, level, tx_on, exp_l[i], exp_lv[i]);
            end
        end
`ifdef USB4_UNDERFLOW_CNT_EN
        n_tests++; if (ucnt !== 8'd2) begin n_fail++; $display("FAIL bonded_underflow got=%0d exp=2", ucnt); end
        go_idle();
        n_tests++; if (ucnt !== 8'd0) begin n_fail++; $display("FAIL underflow_clear got=%0d exp=0", ucnt); end
`endif
    endtask

    task automatic test_single();
        go_idle();
        push_bytes(8'h11, 1);
        push_bytes(8'h22, 1);
        d_sel = 4'd8; bonded = 1'b0;
        tick();
        tick();
        n_tests++; if (lane_tx !== 16'h0011 || level !== 4'd1) begin n_fail++; $display("FAIL single_b0 lane=%h level=%0d exp=0011/1", lane_tx, level); end
        tick();
        n_tests++; if (lane_tx !== 16'h0022 || level !== 4'd0) begin n_fail++; $display("FAIL single_b1 lane=%h level=%0d exp=0022/0", lane_tx, level); end
        tick();
        n_tests++; if (lane_tx !== 16'h0000 || tx_on !== 1'b1) begin n_fail++; $display("FAIL single_pad lane=%h on=%b exp=0000/1", lane_tx, tx_on); end
        bonded = 1'b1;
    endtask

    task automatic test_back_pressure();
        go_idle();
        d_sel = 4'd1;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (tl_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_before%0d got=%b exp=1", i, tl_ready); end
            tl_valid = 1'b1; tl_data = 8'hB0 + 8'(i);
            tick();
        end
        n_tests++; if (level !== 4'd8 || tl_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full level=%0d rdy=%b exp=8/0", level, tl_ready); end
        tl_data = 8'hB8;
        d_sel = 4'd8; bonded = 1'b1;
        tick();
        n_tests++; if (level !== 4'd8 || os_sent !== 1'b1 || lane_tx !== 16'h1313) begin n_fail++; $display("FAIL bp_hold level=%0d os=%b lane=%h exp=8/1/1313", level, os_sent, lane_tx); end
        tl_valid = 1'b0;
        tick();
        n_tests++; if (level !== 4'd6 || lane_tx !== 16'hB1B0 || tl_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain1 level=%0d lane=%h rdy=%b exp=6/b1b0/1", level, lane_tx, tl_ready); end
        tick();
        n_tests++; if (level !== 4'd4 || lane_tx !== 16'hB3B2) begin n_fail++; $display("FAIL bp_drain2 level=%0d lane=%h exp=4/b3b2", level, lane_tx); end
    endtask

    task automatic test_flush();
        go_idle();
        push_bytes(8'hC0, 5);
        d_sel = 4'd8; bonded = 1'b0;
        tick();
        n_tests++; if (level !== 4'd5) begin n_fail++; $display("FAIL flush_pre level=%0d exp=5", level); end
        d_sel = 4'd0; tl_valid = 1'b1; tl_data = 8'hEE;
        #1;
        n_tests++; if (tl_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", tl_ready); end
        tick();
        tl_valid = 1'b0;
        n_tests++; if (level !== 4'd0 || lane_tx !== 16'h0000 || tx_on !== 1'b0 || os_sent !== 1'b0) begin n_fail++; $display("FAIL flush_out level=%0d lane=%h on=%b os=%b exp=0/0000/0/0", level, lane_tx, tx_on, os_sent); end
        d_sel = 4'd15;
        tick();
        n_tests++; if (tx_on !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL flush_idle on=%b level=%0d exp=0/0", tx_on, level); end
        bonded = 1'b1;
    endtask

    task automatic test_reset_mid_data();
        go_idle();
        push_bytes(8'hD0, 5);
        d_sel = 4'd8; bonded = 1'b1;
        tick();
        tick();
        n_tests++; if (lane_tx !== 16'hD1D0 || tx_on !== 1'b1 || level !== 4'd3) begin n_fail++; $display("FAIL rst_mid_pre lane=%h on=%b level=%0d exp=d1d0/1/3", lane_tx, tx_on, level); end
        rst = 1'b1;
        #1;
        n_tests++; if (lane_tx !== 16'h0000 || tx_on !== 1'b0 || level !== 4'd0 || tl_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid lane=%h on=%b level=%0d rdy=%b exp=0000/0/0/0", lane_tx, tx_on, level, tl_ready); end
        tick();
        rst = 1'b0; d_sel = 4'd15;
        tick();
    endtask

    initial begin
        test_reset();
        test_os();
        test_bonded();
        test_single();
        test_back_pressure();
        test_flush();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_tx_nlane.md
Name: data_bus_tx_nlane

Overview:
Parametrised transmit-side data bus for the USB4 logical layer. It generalises the fixed two-lane transmit path to NUM_LANES lanes, with an internal transport-layer byte FIFO using a valid/ready handshake. It has a selectable bonded/single-lane mode and emits ordered sets of OS_LEN bytes under d_sel control. It sits between the logical-layer FSM (d_sel) and the per-lane encoders.

Parameters:
NUM_LANES, 2, number of TX lanes; legal values 1, 2, 4.
FIFO_DEPTH, 8, transport byte FIFO entries; power of 2 and >= NUM_LANES.
OS_LEN, 4, bytes per ordered set per lane; 2..16.

Ports:
fsm_clk  in  1  block clock.
rst  in  1  asynchronous active-high reset.
d_sel  in  4  0 = disconnect/flush, 1..4 = ordered set code, 8 = data, other = idle.
bonded  in  1  1 = stripe over all lanes, 0 = lane 0 only; sampled each pop.
tl_data  in  8  transport-layer byte.
tl_valid  in  1  tl_data valid.
tl_ready  out  1  FIFO can accept a byte this cycle.
lane_tx  out  8*NUM_LANES  lane i = bits [8i+7:8i].
tx_lanes_on  out  1  lanes carry OS or data.
os_sent  out  1  one-cycle pulse with the last byte of each ordered set.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; lane_tx=0, tx_lanes_on=0, os_sent=0, tl_ready=0 while rst is high; fifo_level=0.
- FIFO behaviour:
  - tl_ready = (fifo_level < FIFO_DEPTH) and not rst, combinational from registered level.
  - A push occurs on tl_valid && tl_ready. A byte pushed in cycle t is counted in fifo_level at t+1.
  - Push and pop in the same cycle are allowed; level = level + push - popcount.
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO accepts bytes in every state except when d_sel==0.
- d_sel==0, from any state:
  - Next cycle: FIFO flushed (level 0), state IDLE, all outputs 0.
  - tl_ready is forced 0 while d_sel==0.
- All lane outputs, tx_lanes_on and os_sent are registered: 1-cycle latency from the state/pop decision.
- FSM states are IDLE, OS and DATA.
- IDLE:
  - Lanes 0, tx_lanes_on=0.
  - d_sel in 1..4: go to OS, latch code, k=0.
  - d_sel==8: go to DATA.
- OS:
  - Each cycle, every lane outputs {code, k[3:0]}, tx_lanes_on=1, and k increments.
  - At k==OS_LEN-1: os_sent=1 with that byte. Then re-sample d_sel: 1..4 starts a new OS with the new code (k=0); 8 goes to DATA; other values go to IDLE.
  - A d_sel change mid-OS (other than 0) is ignored until the OS completes.
- DATA:
  - tx_lanes_on=1.
  - bonded=1 and level >= NUM_LANES: pop NUM_LANES bytes; oldest byte goes to lane 0, next to lane 1, and so on.
  - bonded=0 and level >= 1: pop 1 byte to lane 0; other lanes output 0.
  - Insufficient bytes: pop nothing; all lanes output pad 0x00.
  - d_sel in 1..4 goes to OS next cycle. d_sel==8 stays in DATA. Other nonzero values go to IDLE; FIFO contents are kept.
- NUM_LANES=1: bonded is don't-care.
- fifo_level never exceeds FIFO_DEPTH. A pop never exceeds level.

Optional Feature:
USB4_UNDERFLOW_CNT_EN.
- Defined: adds output underflow_cnt, 8 bits, which counts DATA-state cycles where a pad was inserted.
  - Saturates at 255.
  - Cleared by rst and by d_sel==0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: rst=1 mid-DATA with 5 bytes queued -> same cycle lane_tx=0, tx_lanes_on=0, fifo_level=0, tl_ready=0.
2. OS: d_sel=3, OS_LEN=4 -> lanes show 0x30,0x31,0x32,0x33 on all lanes. os_sent is high only with 0x33, then 0x30 repeats. d_sel changed to 8 at the 0x31 byte -> first DATA cycle follows 0x33.
3. Bonded striping, NUM_LANES=2: push 0xA0..0xA5, d_sel=8, bonded=1 -> lane0/lane1 = A0/A1, A2/A3, A4/A5, then 00/00 pads; underflow_cnt increments per pad cycle when enabled.
4. Single-lane: bonded=0, push 0x11,0x22 -> lane0 = 11 then 22; lane1 = 00 throughout.
5. Full/back-pressure, FIFO_DEPTH=8: d_sel=1, push 9 bytes -> tl_ready drops after the 8th byte, fifo_level=8, 9th byte is held by the source. Enter DATA bonded -> level drops 8,6,4,... and tl_ready rises.
6. Flush: level=5 in DATA, d_sel=0 for 1 cycle -> next cycle level=0, outputs 0, state IDLE; tl_ready=0 during that cycle.
